timer_arbiter: RTL
==================

// Module: timer_arbiter
// PURPOSE
//  Shares one down-counting timer among NREQ requesters. Each requester asks for a timeout of len ticks.
//  The block grants the timer round-robin, loads the counter and decrements it on each tick.
//  When the count expires it pulses done to the owner. It sits between the lab FSMs that need delays and the
//  free-running timebase, replacing per-FSM private counters.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  dw    8  counter/length width in bits
// PORTS
//  clk     in   1        system clock, all state on posedge
//  reset   in   1        asynchronous, active-high; clears all state immediately
//  tick    in   1        timebase enable; counter decrements only in cycles where tick=1
//  req     in   NREQ     per-requester request level; held high until done or to cancel
//  len     in   NREQ*dw  flattened lengths; len[i*dw +: dw] belongs to requester i, sampled at grant
//  gnt     out  NREQ     one-hot owner of the timer; all-zero when idle
//  done    out  NREQ     one-cycle pulse to the owner on expiry
//  busy    out  1        1 while state != IDLE
//  count   out  dw       current remaining tick count
// BEHAVIOUR
//  Reset values: state=IDLE, gnt=0, done=0, busy=0, count=0, ptr=NREQ-1 (so req[0] wins first).
//  All outputs come from registers or a state decode; no combinational path from req/tick to outputs.
//  States:
//   IDLE: if |req, winner w = first set bit scanning ptr+1, ptr+2, ... modulo NREQ.
//         At the next edge: gnt<=onehot(w), count<=len[w].
//         If len[w]==0 go to DONE, else go to RUN. If req==0, stay in IDLE.
//   RUN:  if req[owner]==0, cancel: gnt<=0, ptr<=owner, go to IDLE, no done pulse.
//         Else if tick==1 and count==1: count<=0, go to DONE.
//         Else if tick==1: count<=count-1.
//         Else count holds.
//   DONE: done[owner]=1 for exactly this cycle, gnt still held. Next edge: gnt<=0, ptr<=owner, go to IDLE.
//  Latency:
//   - req seen in IDLE -> gnt at the next edge.
//   - len=L>0 -> done pulse in the cycle after the L-th tick sampled in RUN.
//   - A tick in the grant cycle itself is not counted.
//  Cancel has priority over tick in the same RUN cycle.
//  A req change for a non-owner during RUN/DONE has no effect until IDLE.
//  After DONE, the owner must drop req. If it keeps req high it re-arbitrates, but ranks last behind other
//  requesters (fairness).
//  len is sampled only at grant; later changes are ignored.
//  count never wraps: the decrement is gated at count==1 -> 0.
//  Async reset mid-RUN/DONE: immediate return to reset values; no done pulse is emitted.
// STRUCTURE
//  Package timer_arb_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} tarb_state_t; constant MAX_NREQ=8.
//  Sub-module rr_pick #(N): combinational round-robin picker, inputs (req, ptr), outputs (valid, idx, onehot).
//  Timer datapath is inline (load/decrement/hold register). FSM and ptr update live in the top module.
// TESTING
//  1 Reset: assert reset mid-RUN with count=5 -> gnt=0, done=0, busy=0, count=0 without waiting for clk.
//  2 Single: req[0]=1, len0=3, tick=1 every cycle -> gnt=0001 next edge; count 3,2,1,0; done[0] one cycle;
//    gnt=0 the cycle after.
//  3 Round-robin: req[0], req[2] held high, len=2 each -> grant order 0,2,0,2.
//    No requester is granted twice in a row while another is waiting.
//  4 Zero length: req[1]=1, len1=0, tick=0 -> gnt=0010 then DONE next cycle, done[1] pulse, no tick needed.
//  5 Tick gating: len=4, tick high every 3rd cycle -> count steps only on tick cycles; done after 4th tick.
//  6 Cancel: req[3] drops in RUN at count=2 with tick=1 -> IDLE, no done, count frozen;
//    pending req[1] granted next cycle.

Source files
------------

// File: rtl/timer_arb_pkg.sv
// Shared definitions for the timer arbiter slice.
//   tarb_state_t : arbiter FSM encoding (IDLE, RUN, DONE)
//   MAX_NREQ     : largest supported requester count
//   idx_w()      : width of a requester index for a given requester count
package timer_arb_pkg;

   localparam int MAX_NREQ = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tarb_state_t;

   // A single requester still needs a 1-bit index so ports never collapse
   // to zero width.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans req starting at ptr+1 and wrapping modulo N; the first set bit wins,
// so the requester at ptr itself ranks last.
// Ports:
//   req    in  N   request vector
//   ptr    in  IW  index of the most recent owner
//   valid  out 1   at least one request is set
//   idx    out IW  winning index (0 when valid=0)
//   onehot out N   one-hot form of idx (all-zero when valid=0)
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx,
   output logic [N-1:0]  onehot
);

   always_comb begin
      int j;
      valid  = 1'b0;
      idx    = '0;
      onehot = '0;
      j      = 0;
      // Walk from the farthest candidate back to the nearest so the nearest
      // set request (in wrap order after ptr) is the one left standing.
      for (int k = N; k >= 1; k--) begin
         j = int'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (req[j]) begin
            valid = 1'b1;
            idx   = IW'(j);
         end
      end
      if (valid) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one down-counting timer among NREQ requesters.
// A requester raises req[i] with its timeout in len[i*dw +: dw]; the block
// grants round-robin, loads the counter at grant, decrements on each tick
// and pulses done[i] for one cycle when the count expires. Dropping req
// while owning the timer cancels it without a done pulse.
// Ports:
//   clk       in  1        system clock (posedge)
//   reset     in  1        asynchronous active-high reset
//   tick      in  1        timebase enable for the decrement
//   req       in  NREQ     request levels
//   len       in  NREQ*dw  flattened timeout lengths, sampled at grant
//   gnt       out NREQ     one-hot owner, zero when idle
//   done      out NREQ     one-cycle expiry pulse to the owner
//   busy      out 1        state is not IDLE
//   count     out dw       remaining tick count
//   dbg_state out 2        current FSM state, for observation
// Handshake: req is a level held by the requester. gnt rises the edge after
// req is seen in IDLE; the requester keeps req high until it sees done, then
// drops it. Dropping req before done is a cancel.
module timer_arbiter
   import timer_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int dw   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*dw-1:0] len,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic               busy,
   output logic [dw-1:0]      count,
   output tarb_state_t        dbg_state
);

   localparam int IW = idx_w(NREQ);

   tarb_state_t      state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [dw-1:0]    count_q, count_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    owner_q, owner_d;

   logic             pick_valid;
   logic [IW-1:0]    pick_idx;
   logic [NREQ-1:0]  pick_onehot;
   logic [dw-1:0]    pick_len;

   rr_pick #(
      .N  (NREQ),
      .IW (IW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .valid  (pick_valid),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   assign pick_len = len[int'(pick_idx)*dw +: dw];

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      count_d = count_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               gnt_d   = pick_onehot;
               owner_d = pick_idx;
               count_d = pick_len;
               // A zero-length request expires without needing any tick.
               state_d = (pick_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            // Cancel wins over a tick in the same cycle; count stays frozen.
            if (!req[owner_q]) begin
               gnt_d   = '0;
               ptr_d   = owner_q;
               state_d = IDLE;
            end else if (tick) begin
               if (count_q == dw'(1)) begin
                  count_d = '0;
                  state_d = DONE;
               end else if (count_q != '0) begin
                  count_d = count_q - dw'(1);
               end
            end
         end
         DONE: begin
            // Moving ptr to the owner makes it rank last at the next pick.
            gnt_d   = '0;
            ptr_d   = owner_q;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         count_q <= '0;
         ptr_q   <= IW'(NREQ - 1);
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         count_q <= count_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
      end
   end

   assign done      = (state_q == DONE) ? gnt_q : '0;
   assign busy      = (state_q != IDLE);
   assign gnt       = gnt_q;
   assign count     = count_q;
   assign dbg_state = state_q;

endmodule
